axis_mux_pkt: RTL and testbench

//  Packet-aware N:1 AXI4-Stream multiplexer; successor to the 2-input select mux.

---
 rtl/axis_mux_pkg.sv | 11 +
 rtl/axis_skid_reg.sv | 62 ++++++
 rtl/axis_mux_pkt.sv | 133 +++++++++++++
 tb/tb_axis_mux_pkt.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_mux_pkg.sv
// Shared types for the packet-aware AXI4-Stream mux and its register slice.
package axis_mux_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PKT  = 1'b1
   } state_e;

   localparam int unsigned MAX_CH = 16;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-Stream register slice (main + skid); in_ready_o is a pure register output.
module axis_skid_reg #(
   parameter int unsigned W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid_i,
   input  logic [W-1:0] in_data_i,
   output logic         in_ready_o,
   output logic         out_valid_o,
   output logic [W-1:0] out_data_o,
   input  logic         out_ready_i
);

   logic [W-1:0] main_q, main_d, skid_q, skid_d;
   logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic         pop;

   assign pop         = main_vld_q & out_ready_i;
   assign in_ready_o  = ~skid_vld_q;
   assign out_valid_o = main_vld_q;
   assign out_data_o  = main_q;

   // Skid entry refills main first; a push only lands in skid when main is held.
   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (skid_vld_q) begin
         if (pop) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end
      end else if (in_valid_i) begin
         if (!main_vld_q || pop) begin
            main_d     = in_data_i;
            main_vld_d = 1'b1;
         end else begin
            skid_d     = in_data_i;
            skid_vld_d = 1'b1;
         end
      end else if (pop) begin
         main_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

endmodule

// File: rtl/axis_mux_pkt.sv
// Packet-aware N:1 AXI4-Stream mux: one grant per packet, registered output slice.
// Define AXIS_MUX_RR_EN for round-robin arbitration instead of sel-driven grants.
module axis_mux_pkt
   import axis_mux_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH*DATA_W-1:0]   s_axis_tdata,
   input  logic [NUM_CH-1:0]          s_axis_tvalid,
   input  logic [NUM_CH-1:0]          s_axis_tlast,
   output logic [NUM_CH-1:0]          s_axis_tready,
   output logic [DATA_W-1:0]          m_axis_tdata,
   output logic                       m_axis_tvalid,
   output logic                       m_axis_tlast,
   input  logic                       m_axis_tready,
   input  logic [$clog2(NUM_CH)-1:0]  sel,
   output logic [$clog2(NUM_CH)-1:0]  grant_ch,
   output logic                       busy
);

   localparam int unsigned SEL_W = $clog2(NUM_CH);
   localparam int unsigned PW    = DATA_W + 1;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   grant_q, grant_d;
   logic [SEL_W-1:0]   req_ch;
   logic               req_ok;
   logic [PW-1:0]      in_beat;
   logic [PW-1:0]      out_beat;
   logic               accept;
   logic               slice_ready;

`ifdef AXIS_MUX_RR_EN
   logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;

   // First valid channel at or after the pointer, wrapping.
   always_comb begin
      int unsigned idx;
      idx    = 0;
      req_ok = 1'b0;
      req_ch = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx = (32'(rr_ptr_q) + i) % NUM_CH;
         if (!req_ok && s_axis_tvalid[SEL_W'(idx)]) begin
            req_ok = 1'b1;
            req_ch = SEL_W'(idx);
         end
      end
   end
`else
   always_comb begin
      req_ok = 1'b0;
      req_ch = sel;
      if (32'(sel) < NUM_CH) req_ok = s_axis_tvalid[sel];
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
`ifdef AXIS_MUX_RR_EN
         rr_ptr_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
`ifdef AXIS_MUX_RR_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
`ifdef AXIS_MUX_RR_EN
      rr_ptr_d = rr_ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_ok) begin
               state_d = PKT;
               grant_d = req_ch;
`ifdef AXIS_MUX_RR_EN
               rr_ptr_d = SEL_W'((32'(req_ch) + 1) % NUM_CH);
`endif
            end
         end
         PKT:     if (accept && in_beat[DATA_W]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Ready only toward the granted channel, and only from registered state.
   always_comb begin
      s_axis_tready = '0;
      busy          = (state_q == PKT);
      if (state_q == PKT) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant_q == SEL_W'(i)) s_axis_tready[i] = slice_ready;
         end
      end
   end

   always_comb begin
      in_beat = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (grant_q == SEL_W'(i)) in_beat = {s_axis_tlast[i], s_axis_tdata[i*DATA_W +: DATA_W]};
      end
   end

   assign accept   = |(s_axis_tready & s_axis_tvalid);
   assign grant_ch = grant_q;

   axis_skid_reg #(.W(PW)) u_slice (
      .clk         (clk),
      .reset       (reset),
      .in_valid_i  (accept),
      .in_data_i   (in_beat),
      .in_ready_o  (slice_ready),
      .out_valid_o (m_axis_tvalid),
      .out_data_o  (out_beat),
      .out_ready_i (m_axis_tready)
   );

   assign m_axis_tdata = out_beat[DATA_W-1:0];
   assign m_axis_tlast = out_beat[DATA_W];

endmodule

// File: tb/tb_axis_mux_pkt.sv
// Scoreboard bench for axis_mux_pkt (5 channels so out-of-range sel is representable).
module tb_axis_mux_pkt;

   localparam int NCH = 5;
   localparam int DW  = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [NCH*DW-1:0] s_axis_tdata;
   logic [NCH-1:0]    s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [DW-1:0]     m_axis_tdata;
   logic              m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic [2:0]        sel, grant_ch;
   logic              busy;

   logic              tv [NCH];
   logic [DW-1:0]     td [NCH];
   logic              tl [NCH];
   int                acc [NCH];
   bit                abort;

   logic [8:0]        sb [$];
   int                pop_cyc [$];
   int                cyc = 0;
   int                tests = 0;
   int                fails = 0;

   axis_mux_pkt #(.NUM_CH(NCH), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .sel(sel), .grant_ch(grant_ch), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         s_axis_tdata[i*DW +: DW] = td[i];
         s_axis_tvalid[i]         = tv[i];
         s_axis_tlast[i]          = tl[i];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every presented beat must match the scoreboard head; pop on handshake.
   always @(negedge clk) begin
      if (!reset && m_axis_tvalid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got 0x%0h expected none", {m_axis_tlast, m_axis_tdata});
         end else begin
            chk("out_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(sb[0]));
            if (m_axis_tready) begin
               void'(sb.pop_front());
               pop_cyc.push_back(cyc);
            end
         end
      end
   end

   task automatic send_pkt(input int ch, input int n, input logic [7:0] base, input bit push);
      if (push) for (int i = 0; i < n; i++) sb.push_back({1'(i == n - 1), 8'(base + 8'(i))});
      for (int i = 0; i < n; i++) begin
         int  waitc;
         bit  ok;
         waitc  = 0;
         ok     = 1'b0;
         tv[ch] = 1'b1;
         td[ch] = base + 8'(i);
         tl[ch] = (i == n - 1);
         while (!ok && !abort && waitc < 200) begin
            @(negedge clk);
            if (!abort && s_axis_tready[ch]) ok = 1'b1;
            else waitc++;
         end
         if (ok) begin
            @(posedge clk);
            #1;
            acc[ch]++;
         end else begin
            if (!abort) begin
               tests++;
               fails++;
               $display("FAIL handshake_timeout: ch%0d beat %0d never accepted", ch, i);
            end
            tv[ch] = 1'b0;
            tl[ch] = 1'b0;
            return;
         end
      end
      tv[ch] = 1'b0;
      tl[ch] = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("drain_empty", 32'(sb.size()), 0);
   endtask

   task automatic rr_src(input int ch);
      for (int k = 0; k < 2; k++) send_pkt(ch, 1, 8'(ch), 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      abort = 1'b0;
      m_axis_tready = 1'b1;
      sel = 3'd0;
      for (int i = 0; i < NCH; i++) begin
         tv[i] = 1'b0; td[i] = '0; tl[i] = 1'b0; acc[i] = 0;
      end
      #3;
      chk("rst_outputs", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready, grant_ch, busy}), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;

`ifdef AXIS_MUX_RR_EN
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < NCH; c++) sb.push_back({1'b1, 8'(c)});
      fork
         rr_src(0); rr_src(1); rr_src(2); rr_src(3); rr_src(4);
      join
      drain();
`else
      begin : t1
         int n0;
         n0 = pop_cyc.size();
         sel = 3'd2;
         send_pkt(2, 3, 8'hA0, 1'b1);
         repeat (3) @(negedge clk);
         chk("t1_pop_count", 32'(pop_cyc.size() - n0), 3);
         if (pop_cyc.size() >= n0 + 3) chk("t1_back_to_back", 32'(pop_cyc[n0+2] - pop_cyc[n0]), 2);
         chk("t1_busy_after", 32'(busy), 0);
         drain();
      end

      begin : t2
         int a2;
         a2 = acc[2];
         sel = 3'd2;
         for (int i = 0; i < 4; i++) sb.push_back({1'(i == 3), 8'(8'h20 + 8'(i))});
         for (int i = 0; i < 3; i++) sb.push_back({1'(i == 2), 8'(8'hC0 + 8'(i))});
         fork
            send_pkt(2, 4, 8'h20, 1'b0);
            send_pkt(0, 3, 8'hC0, 1'b0);
            begin
               int w;
               w = 0;
               while (acc[2] < a2 + 1 && w < 100) begin @(negedge clk); w++; end
               sel = 3'd0;
               @(negedge clk);
               chk("t2_grant_held", 32'(grant_ch), 2);
            end
         join
         drain();
      end

      begin : t3
         sel = 3'd1;
         fork
            send_pkt(1, 6, 8'h30, 1'b1);
            begin
               int w;
               w = 0;
               do begin @(negedge clk); w++; end while (!m_axis_tvalid && w < 50);
               @(posedge clk); #1;
               @(posedge clk); #1 m_axis_tready = 1'b0;
               @(negedge clk);
               @(negedge clk);
               chk("t3_sready_drop", 32'(s_axis_tready), 0);
               @(posedge clk); #1 m_axis_tready = 1'b1;
            end
         join
         drain();
      end

      begin : t4
         sel = 3'd5;
         for (int c = 0; c < NCH; c++) begin tv[c] = 1'b1; td[c] = 8'hE0 + 8'(c); end
         repeat (5) begin
            @(negedge clk);
            chk("t4_sel5_idle", 32'({s_axis_tready, m_axis_tvalid, busy}), 0);
         end
         sel = 3'd7;
         repeat (3) begin
            @(negedge clk);
            chk("t4_sel7_idle", 32'({s_axis_tready, m_axis_tvalid, busy}), 0);
         end
         @(posedge clk);
         #1;
         for (int c = 0; c < NCH; c++) tv[c] = 1'b0;
      end

      begin : t5
         int a3;
         a3 = acc[3];
         sel = 3'd3;
         fork
            send_pkt(3, 5, 8'h50, 1'b1);
            begin
               int w;
               w = 0;
               while (acc[3] < a3 + 2 && w < 100) begin @(negedge clk); w++; end
               chk("t5_reached_beat2", 32'(acc[3] >= a3 + 2), 1);
               reset = 1'b1;
               abort = 1'b1;
               #1;
               chk("t5_rst_outputs", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready, grant_ch, busy}), 0);
            end
         join
         sb.delete();
         repeat (2) @(posedge clk);
         #1;
         reset = 1'b0;
         abort = 1'b0;
         send_pkt(3, 3, 8'h70, 1'b1);
         drain();
      end
`endif

      repeat (3) @(negedge clk);
      chk("end_idle", 32'({busy, m_axis_tvalid}), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
